hash_display_sched: RTL and testbench

//  Schedules updates of the on-screen hash text. Accepts {inhash,outhash} result pairs from the

---
 rtl/hash_display_sched_pkg.sv | 17 +
 rtl/hash_display_sched_if.sv | 25 ++
 rtl/hash_display_sched_frame_tick.sv | 46 ++++
 rtl/hash_display_sched.sv | 94 +++++++++
 tb/tb_hash_display_sched.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hash_display_sched_pkg.sv
// Shared constants and state encoding for the hash display scheduler.
// Imported by the interface, the frame tick helper and the top.
package hash_display_sched_pkg;

  localparam int V_VIS     = 480;
  localparam int H_VIS     = 640;
  localparam int INHASH_W  = 1024;
  localparam int OUTHASH_W = 256;
  localparam int Y_W       = 11;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/hash_display_sched_if.sv
// Result-pair handshake between the mining core (master)
// and the display scheduler (slave).
interface hash_display_sched_if;
  import hash_display_sched_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [INHASH_W-1:0]  inhash;
  logic [OUTHASH_W-1:0] outhash;

  modport master (
    output valid,
    output inhash,
    output outhash,
    input  ready
  );

  modport slave (
    input  valid,
    input  inhash,
    input  outhash,
    output ready
  );

endinterface

// File: rtl/hash_display_sched_frame_tick.sv
// Start-of-vblank tick and saturating frame hold counter.
// hold_ok means this tick brings the hold up to HOLD_FRAMES.
module hash_display_sched_frame_tick #(
  parameter int V_VIS       = 480,
  parameter int HOLD_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] y,
  input  logic        commit,
  output logic        tick,
  output logic        hold_ok
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  logic          vblank;
  logic          vblank_q;
  logic [HW-1:0] hold_cnt;

  assign vblank  = (y >= 11'(V_VIS));
  assign tick    = vblank & ~vblank_q;
  assign hold_ok = tick & (hold_cnt >= HOLD_LAST);

  // vblank_q resets high so a release inside vblank yields no tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vblank_q <= 1'b1;
    end else begin
      vblank_q <= vblank;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= HOLD_MAX;
    end else if (commit) begin
      hold_cnt <= '0;
    end else if (tick && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hash_display_sched.sv
// Buffers one hash pair and commits it to the display
// registers only at the start of vblank, rate-limited.
module hash_display_sched #(
  parameter int V_VIS       = hash_display_sched_pkg::V_VIS,
  parameter int HOLD_FRAMES = 30,
  parameter bit DROP_OLD    = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] y,
  hash_display_sched_if.slave core,
  input  logic        freeze,
  output logic [hash_display_sched_pkg::INHASH_W-1:0]  disp_inhash,
  output logic [hash_display_sched_pkg::OUTHASH_W-1:0] disp_outhash,
  output logic        pending,
  output logic [CNT_W-1:0] update_count
);
  import hash_display_sched_pkg::*;

  state_e state_q;
  state_e state_d;
  logic   ready_q;
  logic   ready_d;
  logic   hs;
  logic   commit;
  logic   tick;
  logic   hold_ok;

  logic [INHASH_W-1:0]  sh_in;
  logic [OUTHASH_W-1:0] sh_out;

  assign core.ready = ready_q;
  assign hs         = core.valid & ready_q;
  assign commit     = (state_q == ST_COMMIT);

  hash_display_sched_frame_tick #(
    .V_VIS       (V_VIS),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_frame_tick (
    .clk     (clk),
    .reset   (reset),
    .y       (y),
    .commit  (commit),
    .tick    (tick),
    .hold_ok (hold_ok)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY:  if (hs) state_d = ST_FULL;
      ST_FULL:   if (hold_ok && !freeze) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
    ready_d = (state_d == ST_EMPTY) ||
              ((state_d == ST_FULL) && DROP_OLD);
  end

  // ready is registered: low in reset, high from the first edge after
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      pending <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      pending <= (state_d != ST_EMPTY);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_in        <= '0;
      sh_out       <= '0;
      disp_inhash  <= '0;
      disp_outhash <= '0;
      update_count <= '0;
    end else begin
      if (hs) begin
        sh_in  <= core.inhash;
        sh_out <= core.outhash;
      end
      if (commit) begin
        disp_inhash  <= sh_in;
        disp_outhash <= sh_out;
        update_count <= update_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hash_display_sched.sv
// Bench for hash_display_sched: two instances (keep-old and drop-old)
// share stimulus and are compared every cycle to a pair-level model.
module tb_hash_display_sched;
  import hash_display_sched_pkg::*;

  localparam int HOLD = 30;
  localparam int VV   = 480;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [10:0]   y;
  logic          valid;
  logic          freeze;
  logic [1023:0] din_i;
  logic [255:0]  din_o;

  hash_display_sched_if if0 ();
  hash_display_sched_if if1 ();

  assign if0.valid   = valid;
  assign if0.inhash  = din_i;
  assign if0.outhash = din_o;
  assign if1.valid   = valid;
  assign if1.inhash  = din_i;
  assign if1.outhash = din_o;

  logic [1023:0] q0_di, q1_di;
  logic [255:0]  q0_do, q1_do;
  logic          q0_pend, q1_pend;
  logic [15:0]   q0_cnt, q1_cnt;

  hash_display_sched #(
    .HOLD_FRAMES (HOLD),
    .DROP_OLD    (1'b0)
  ) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .y            (y),
    .core         (if0),
    .freeze       (freeze),
    .disp_inhash  (q0_di),
    .disp_outhash (q0_do),
    .pending      (q0_pend),
    .update_count (q0_cnt)
  );

  hash_display_sched #(
    .HOLD_FRAMES (HOLD),
    .DROP_OLD    (1'b1)
  ) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .y            (y),
    .core         (if1),
    .freeze       (freeze),
    .disp_inhash  (q1_di),
    .disp_outhash (q1_do),
    .pending      (q1_pend),
    .update_count (q1_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int d,
                     input logic [1023:0] act,
                     input logic [1023:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h want %h (low 128 bits)",
                  nm, d, act[127:0], exp[127:0]);
  endtask

  // Pair-level model: one shadow slot, a commit due flag, ticks since last commit
  typedef struct {
    logic          ready;
    logic          full;
    logic          cmt;
    logic [1023:0] shi;
    logic [1023:0] di;
    logic [255:0]  sho;
    logic [255:0]  dout;
    logic [15:0]   cnt;
    int            ticks;
  } ms_t;

  ms_t  ms [2];
  logic vbp;
  logic m_tick;
  assign m_tick = (y >= 11'(VV)) && !vbp;

  function automatic ms_t m_rst();
    ms_t n;
    n.ready = 1'b0; n.full = 1'b0; n.cmt = 1'b0;
    n.shi = '0; n.di = '0; n.sho = '0; n.dout = '0;
    n.cnt = '0; n.ticks = HOLD;
    return n;
  endfunction

  function automatic ms_t m_next(ms_t s, bit drop, logic tk,
                                 logic v, logic fz,
                                 logic [1023:0] ni,
                                 logic [255:0] no);
    ms_t n = s;
    if (s.cmt) begin
      n.di = s.shi; n.dout = s.sho;
      n.cnt = s.cnt + 16'd1;
      n.ticks = 0; n.full = 1'b0; n.cmt = 1'b0;
    end else begin
      if (tk && s.ticks < HOLD) n.ticks = s.ticks + 1;
      if (v && s.ready) begin
        n.shi = ni; n.sho = no; n.full = 1'b1;
      end
      if (s.full && tk && !fz && n.ticks == HOLD) n.cmt = 1'b1;
    end
    n.ready = !n.cmt && (!n.full || drop);
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms[0] <= m_rst();
      ms[1] <= m_rst();
      vbp   <= 1'b1;
    end else begin
      ms[0] <= m_next(ms[0], 1'b0, m_tick, valid, freeze, din_i, din_o);
      ms[1] <= m_next(ms[1], 1'b1, m_tick, valid, freeze, din_i, din_o);
      vbp   <= (y >= 11'(VV));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",   0, if0.ready, ms[0].ready);
      chk("pending", 0, q0_pend,   ms[0].full | ms[0].cmt);
      chk("count",   0, q0_cnt,    ms[0].cnt);
      chk("outhash", 0, q0_do,     ms[0].dout);
      chk("inhash",  0, q0_di,     ms[0].di);
      chk("ready",   1, if1.ready, ms[1].ready);
      chk("pending", 1, q1_pend,   ms[1].full | ms[1].cmt);
      chk("count",   1, q1_cnt,    ms[1].cnt);
      chk("outhash", 1, q1_do,     ms[1].dout);
      chk("inhash",  1, q1_di,     ms[1].di);
    end
  end

  function automatic logic [1023:0] rnd_in();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] rnd_out();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cyc(input int ny);
    y = 11'(ny);
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    for (int l = 0; l <= 512; l += 16) cyc(l);
  endtask

  logic [1023:0] a_i;
  logic [255:0]  b_o, c_o, d_o, e_o, f_o, g_o;

  initial begin
    reset = 1'b1; valid = 1'b0; freeze = 1'b0;
    y = 11'd100; din_i = '0; din_o = '0;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 0, if0.ready, 0);
    chk("rst_disp",  0, q0_do,     0);
    chk("rst_cnt",   1, q1_cnt,    0);
    chk("rst_pend",  0, q0_pend,   0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("t1_ready", 0, if0.ready, 1);

    // pair A, committed at the first tick
    a_i = rnd_in();
    din_i = a_i; din_o = 256'h1; valid = 1'b1;
    cyc(100);
    valid = 1'b0;
    chk("t1_pend",      0, q0_pend,   1);
    chk("t1_ready_old", 0, if0.ready, 0);
    chk("t1_ready_new", 1, if1.ready, 1);
    for (int l = 116; l <= 464; l += 16) cyc(l);
    chk("t1_pre_vbl", 0, q0_do, 0);
    cyc(480);
    chk("t1_tick_edge", 0, q0_do, 0);
    cyc(480);
    chk("t1_disp_out", 0, q0_do,   1);
    chk("t1_disp_in",  0, q0_di,   a_i);
    chk("t1_cnt",      0, q0_cnt,  1);
    chk("t1_pend_clr", 0, q0_pend, 0);

    // B waits 30 ticks after A
    b_o = rnd_out();
    din_i = rnd_in(); din_o = b_o; valid = 1'b1;
    cyc(496);
    valid = 1'b0;
    cyc(512);
    repeat (29) frame();
    chk("t2_hold_cnt",  0, q0_cnt,  1);
    chk("t2_hold_pend", 1, q1_pend, 1);
    frame();
    chk("t2_cnt",  0, q0_cnt, 2);
    chk("t2_disp", 1, q1_do,  b_o);

    // C then D held: keep-old backpressures, drop-old shows D
    c_o = rnd_out();
    din_i = rnd_in(); din_o = c_o; valid = 1'b1;
    cyc(0);
    d_o = rnd_out();
    din_i = rnd_in(); din_o = d_o;
    chk("t3_bp", 0, if0.ready, 0);
    repeat (30) frame();
    chk("t3_old_disp", 0, q0_do,   c_o);
    chk("t3_old_cnt",  0, q0_cnt,  3);
    chk("t3_old_pend", 0, q0_pend, 1);
    chk("t4_new_disp", 1, q1_do,   d_o);
    chk("t4_new_cnt",  1, q1_cnt,  3);
    valid = 1'b0;
    repeat (30) frame();
    chk("t3_d_disp", 0, q0_do,  d_o);
    chk("t3_d_cnt",  0, q0_cnt, 4);

    // freeze across 100 frames
    e_o = rnd_out();
    din_i = rnd_in(); din_o = e_o; valid = 1'b1;
    cyc(0);
    valid = 1'b0; freeze = 1'b1;
    repeat (100) frame();
    chk("t5_frz_cnt",  0, q0_cnt,  4);
    chk("t5_frz_disp", 1, q1_do,   d_o);
    chk("t5_frz_pend", 0, q0_pend, 1);
    for (int l = 0; l <= 192; l += 16) cyc(l);
    freeze = 1'b0;
    cyc(200);
    for (int l = 216; l <= 464; l += 16) cyc(l);
    chk("t5_unfrz_early", 0, q0_cnt, 4);
    cyc(480);
    chk("t5_tick_edge", 1, q1_cnt, 4);
    cyc(496);
    chk("t5_cnt",  0, q0_cnt, 5);
    chk("t5_disp", 0, q0_do,  e_o);

    // reset during COMMIT, release inside vblank
    f_o = rnd_out();
    din_i = rnd_in(); din_o = f_o; valid = 1'b1;
    cyc(512);
    valid = 1'b0;
    repeat (29) frame();
    for (int l = 0; l <= 464; l += 16) cyc(l);
    cyc(480);
    y = 11'd481;
    #2 reset = 1'b0;
    #1;
    chk("t6_disp",  0, q0_do,     0);
    chk("t6_cnt",   1, q1_cnt,    0);
    chk("t6_pend",  0, q0_pend,   0);
    chk("t6_ready", 1, if1.ready, 0);
    @(posedge clk); #1;
    y = 11'd490;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    g_o = rnd_out();
    din_i = rnd_in(); din_o = g_o; valid = 1'b1;
    cyc(500);
    valid = 1'b0;
    cyc(512);
    cyc(524);
    for (int l = 0; l <= 464; l += 16) cyc(l);
    chk("t6_no_tick", 0, q0_cnt,  0);
    chk("t6_pend2",   0, q0_pend, 1);
    cyc(480);
    cyc(496);
    chk("t6_cnt2", 0, q0_cnt, 1);
    chk("t6_disp2", 1, q1_do, g_o);

    // randomized traffic
    for (int k = 0; k < 12000; k++) begin
      int ny;
      valid = ($urandom_range(0, 2) != 0);
      if (valid) begin
        din_i = rnd_in();
        din_o = rnd_out();
      end
      if ($urandom_range(0, 399) == 0) freeze = ~freeze;
      ny = (int'(y) + int'($urandom_range(1, 24))) % 525;
      if ($urandom_range(0, 1999) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      cyc(ny);
    end
    valid = 1'b0; freeze = 1'b0;
    repeat (40) frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
